// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage: FSM state encoding and the MEM/WB register payload.
package mem_stage_pkg;

  localparam int WORD_W  = 32;
  // Destination-index width carried in the MEM/WB payload; the top-level WA_W should match it.
  localparam int WB_WA_W = 4;

  typedef enum logic [0:0] {IDLE, ACCESS} mem_state_t;

  typedef struct packed {
    logic                mem_to_reg;
    logic                reg_write;
    logic [WORD_W-1:0]   read_data;
    logic [WORD_W-1:0]   aluResult;
    logic [WB_WA_W-1:0]  WA3;
    logic [WORD_W-1:0]   pc_count;
  } mem_wb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A bubble clears only the write-back controls and holds the data fields.
module mem_wb_reg
  import mem_stage_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    load,
  input  logic    bubble,
  input  mem_wb_t d,
  output mem_wb_t q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (bubble) begin
      q.reg_write  <= 1'b0;
      q.mem_to_reg <= 1'b0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: runs load/store over the req/ack data bus, stalls upstream until ack, owns MEM/WB.
// Optional bus timeout with sticky bus_err is enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W         = 30,
  parameter int WA_W           = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_to_reg,
  input  logic              mem_write,
  input  logic              reg_write,
  input  logic [31:0]       pc_count,
  input  logic [31:0]       RD2,
  input  logic [31:0]       aluResult,
  input  logic [WA_W-1:0]   WA3,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              mem_to_reg_wb,
  output logic              reg_write_wb,
  output logic [31:0]       read_data_wb,
  output logic [31:0]       aluResult_wb,
  output logic [WA_W-1:0]   WA3_wb,
  output logic [31:0]       pc_count_wb,
  output logic              bus_err
);

  mem_state_t        state, state_nxt;
  logic              mem_op;
  logic              latch_en;
  logic              wb_load;
  logic              wb_bubble;
  logic              stall_c;
  logic              timeout;
  logic              lat_mem_to_reg;
  logic              lat_reg_write;
  logic [WORD_W-1:0] lat_alu;
  logic [WORD_W-1:0] lat_pc;
  logic [WA_W-1:0]   lat_wa3;
  mem_wb_t           wb_d;
  mem_wb_t           wb_q;

  assign mem_op = mem_to_reg | mem_write;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request and instruction fields are captured once, as the op leaves IDLE, so upstream may change after ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      lat_mem_to_reg <= 1'b0;
      lat_reg_write  <= 1'b0;
      lat_alu        <= '0;
      lat_wa3        <= '0;
      lat_pc         <= '0;
    end else if (latch_en) begin
      dmem_we        <= mem_write;
      dmem_addr      <= aluResult[ADDR_W+1:2];
      dmem_wdata     <= RD2;
      lat_mem_to_reg <= mem_to_reg & ~mem_write;
      lat_reg_write  <= reg_write;
      lat_alu        <= aluResult;
      lat_wa3        <= WA3;
      lat_pc         <= pc_count;
    end
  end

  always_comb begin
    state_nxt = state;
    stall_c   = 1'b0;
    latch_en  = 1'b0;
    wb_load   = 1'b0;
    wb_bubble = 1'b0;
    wb_d      = '0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          stall_c   = 1'b1;
          latch_en  = 1'b1;
          wb_bubble = 1'b1;
          state_nxt = ACCESS;
        end else begin
          wb_load         = 1'b1;
          wb_d.mem_to_reg = mem_to_reg;
          wb_d.reg_write  = reg_write;
          wb_d.aluResult  = aluResult;
          wb_d.WA3        = WB_WA_W'(WA3);
          wb_d.pc_count   = pc_count;
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          wb_load         = 1'b1;
          wb_d.mem_to_reg = lat_mem_to_reg;
          wb_d.reg_write  = lat_reg_write;
          wb_d.read_data  = dmem_we ? '0 : dmem_rdata;
          wb_d.aluResult  = lat_alu;
          wb_d.WA3        = WB_WA_W'(lat_wa3);
          wb_d.pc_count   = lat_pc;
          state_nxt       = IDLE;
        end else if (timeout) begin
          wb_bubble = 1'b1;
          state_nxt = IDLE;
        end else begin
          stall_c   = 1'b1;
          wb_bubble = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Gated with reset so every output reads 0 while reset is held, whatever EX/MEM presents.
  assign stall    = stall_c & rst;
  assign dmem_req = (state == ACCESS);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] to_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (state == IDLE) begin
      to_cnt <= '0;
    end else if (!dmem_ack) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout = (state == ACCESS) && !dmem_ack && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_err <= 1'b0;
    end else if (timeout) begin
      bus_err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

  mem_wb_reg u_mem_wb_reg (
    .clk    (clk),
    .rst    (rst),
    .load   (wb_load),
    .bubble (wb_bubble),
    .d      (wb_d),
    .q      (wb_q)
  );

  assign mem_to_reg_wb = wb_q.mem_to_reg;
  assign reg_write_wb  = wb_q.reg_write;
  assign read_data_wb  = wb_q.read_data;
  assign aluResult_wb  = wb_q.aluResult;
  assign WA3_wb        = WA_W'(wb_q.WA3);
  assign pc_count_wb   = wb_q.pc_count;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomised and directed bench for mem_access_stage against a per-instruction reference model.
// Covers the timeout path when built with MEM_TIMEOUT_EN defined.
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic        mem_to_reg, mem_write, reg_write;
  logic [31:0] pc_count, RD2, aluResult;
  logic [3:0]  WA3;
  logic        stall, dmem_req, dmem_we;
  logic [29:0] dmem_addr;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        mem_to_reg_wb, reg_write_wb;
  logic [31:0] read_data_wb, aluResult_wb, pc_count_wb;
  logic [3:0]  WA3_wb;
  logic        bus_err;

  int total;
  int bad;
  // Data fields MEM/WB should hold across bubbles: {read_data, aluResult, WA3, pc_count}.
  logic [99:0] held;

  mem_access_stage #(.ADDR_W(30), .WA_W(4), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .mem_to_reg(mem_to_reg), .mem_write(mem_write), .reg_write(reg_write),
    .pc_count(pc_count), .RD2(RD2), .aluResult(aluResult), .WA3(WA3),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .mem_to_reg_wb(mem_to_reg_wb), .reg_write_wb(reg_write_wb),
    .read_data_wb(read_data_wb), .aluResult_wb(aluResult_wb),
    .WA3_wb(WA3_wb), .pc_count_wb(pc_count_wb), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One instruction from EX/MEM to MEM/WB. delay = ACCESS cycles without ack before the ack cycle.
  task automatic run_instr(input logic mtr, input logic mw, input logic rw,
                           input logic [31:0] pc, input logic [31:0] rd2,
                           input logic [31:0] alu, input logic [3:0] wa,
                           input int delay, input logic spur, input logic [31:0] rdata);
    logic        mem;
    logic [101:0] exp_wb;
    logic [101:0] obs_wb;
    logic [63:0] exp_bus;
    logic [63:0] obs_bus;
    mem = mtr | mw;
    mem_to_reg = mtr; mem_write = mw; reg_write = rw;
    pc_count = pc; RD2 = rd2; aluResult = alu; WA3 = wa;
    dmem_ack = spur; dmem_rdata = $urandom;
    #1;
    total++;
    if ({stall, dmem_req} !== {mem, 1'b0}) begin
      bad++;
      $display("[TB] FAIL idle_stall_req: got %b want %b", {stall, dmem_req}, {mem, 1'b0});
    end
    @(posedge clk); #1;
    if (!mem) begin
      exp_wb = {1'b0, rw, 32'h0, alu, wa, pc};
      held   = {32'h0, alu, wa, pc};
    end else begin
      exp_wb = {2'b00, held};
      for (int c = 0; c <= delay; c++) begin
        dmem_ack   = (c == delay);
        dmem_rdata = (c == delay) ? rdata : $urandom;
        #1;
        obs_bus = {dmem_req, dmem_we, dmem_addr, dmem_wdata, stall};
        exp_bus = {1'b1, mw, alu[31:2], rd2, (c != delay)};
        total++;
        if (obs_bus !== exp_bus) begin
          bad++;
          $display("[TB] FAIL access_bus c=%0d: got %h want %h", c, obs_bus, exp_bus);
        end
        @(posedge clk); #1;
        if (c == delay) begin
          held   = {mw ? 32'h0 : rdata, alu, wa, pc};
          exp_wb = {mtr & ~mw, rw, held};
        end else begin
          obs_wb = {mem_to_reg_wb, reg_write_wb, read_data_wb, aluResult_wb, WA3_wb, pc_count_wb};
          total++;
          if (obs_wb !== {2'b00, held}) begin
            bad++;
            $display("[TB] FAIL bubble c=%0d: got %h want %h", c, obs_wb, {2'b00, held});
          end
        end
      end
    end
    dmem_ack = 1'b0;
    obs_wb = {mem_to_reg_wb, reg_write_wb, read_data_wb, aluResult_wb, WA3_wb, pc_count_wb};
    total++;
    if (obs_wb !== exp_wb) begin
      bad++;
      $display("[TB] FAIL mem_wb: got %h want %h", obs_wb, exp_wb);
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [167:0] obs;
    obs = {stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_to_reg_wb, reg_write_wb,
           read_data_wb, aluResult_wb, WA3_wb, pc_count_wb, bus_err};
    total++;
    if (obs !== '0) begin
      bad++;
      $display("[TB] FAIL %s: got %h want 0", name, obs);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    mem_to_reg = 1'b1; mem_write = 1'b0; reg_write = 1'b1;
    pc_count = 32'h10; RD2 = 32'h5; aluResult = 32'h100; WA3 = 4'd3;
    dmem_ack = 1'b1; dmem_rdata = 32'h1;
    #3;
    check_all_zero("reset_outputs");
    mem_to_reg = 1'b0; reg_write = 1'b0; dmem_ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    held = '0;
  endtask

  task automatic test_alu_op();
    run_instr(1'b0, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 32'h0000_1234, 4'd5, 0, 1'b0, 32'h0);
  endtask

  task automatic test_load();
    run_instr(1'b1, 1'b0, 1'b1, 32'h0000_0044, 32'h0, 32'h0000_0100, 4'd7, 3, 1'b0, 32'hDEAD_BEEF);
  endtask

  task automatic test_store();
    run_instr(1'b0, 1'b1, 1'b0, 32'h0000_0048, 32'hCAFE_0001, 32'h0000_0008, 4'd2, 0, 1'b0, 32'h1111_2222);
  endtask

  task automatic test_back_to_back();
    run_instr(1'b0, 1'b1, 1'b0, 32'h0000_0050, 32'h1234_5678, 32'h0000_0200, 4'd1, 0, 1'b0, 32'h0);
    run_instr(1'b1, 1'b0, 1'b1, 32'h0000_0054, 32'h0, 32'h0000_0200, 4'd9, 0, 1'b0, 32'h1234_5678);
    run_instr(1'b1, 1'b1, 1'b1, 32'h0000_0058, 32'hA5A5_5A5A, 32'h0000_0307, 4'd4, 1, 1'b1, 32'hFFFF_0000);
  endtask

  task automatic test_random();
    logic [1:0] kind;
    for (int i = 0; i < 60; i++) begin
      kind = 2'($urandom_range(0, 3));
      run_instr(kind[0], kind[1], 1'($urandom), $urandom, $urandom, $urandom,
                4'($urandom), $urandom_range(0, 3), 1'($urandom), $urandom);
    end
  endtask

  task automatic test_reset_mid_access();
    mem_to_reg = 1'b0; mem_write = 1'b1; reg_write = 1'b0;
    pc_count = 32'h60; RD2 = 32'h7777_8888; aluResult = 32'h400; WA3 = 4'd6;
    dmem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if (dmem_req !== 1'b1) begin
      bad++;
      $display("[TB] FAIL pre_reset_req: got %b want 1", dmem_req);
    end
    rst = 1'b0;
    #1;
    check_all_zero("reset_mid_access");
    mem_write = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    held = '0;
    run_instr(1'b0, 1'b0, 1'b1, 32'h0000_0064, 32'h0, 32'h0000_ABCD, 4'd11, 0, 1'b0, 32'h0);
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    mem_to_reg = 1'b1; mem_write = 1'b0; reg_write = 1'b1;
    pc_count = 32'h70; RD2 = 32'h0; aluResult = 32'h800; WA3 = 4'd8;
    dmem_ack = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++;
      if ({dmem_req, stall} !== {1'b1, (c < 3)}) begin
        bad++;
        $display("[TB] FAIL timeout_access c=%0d: got %b want %b", c, {dmem_req, stall}, {1'b1, (c < 3)});
      end
      @(posedge clk); #1;
    end
    total++;
    if ({bus_err, dmem_req, mem_to_reg_wb, reg_write_wb} !== 4'b1000) begin
      bad++;
      $display("[TB] FAIL timeout_abort: got %b want 1000", {bus_err, dmem_req, mem_to_reg_wb, reg_write_wb});
    end
    mem_to_reg = 1'b0;
    run_instr(1'b0, 1'b0, 1'b1, 32'h0000_0074, 32'h0, 32'h0000_0042, 4'd3, 0, 1'b0, 32'h0);
    total++;
    if (bus_err !== 1'b1) begin
      bad++;
      $display("[TB] FAIL bus_err_sticky: got %b want 1", bus_err);
    end
  endtask
`else
  task automatic test_long_wait();
    run_instr(1'b1, 1'b0, 1'b1, 32'h0000_0080, 32'h0, 32'h0000_0900, 4'd12, 20, 1'b0, 32'h0BAD_F00D);
    total++;
    if (bus_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL bus_err_tied: got %b want 0", bus_err);
    end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_alu_op();
    test_load();
    test_store();
    test_back_to_back();
    test_random();
    test_reset_mid_access();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
